// File: rtl/reg_file_pkg.sv
// Shared core definitions: RoB geometry, architectural register count and
// the instruction-type encodings used by the decoder, the RoB and the register file.
package reg_file_pkg;

    localparam int unsigned RoB_WIDTH = 3;
    localparam int unsigned RoB_SIZE  = 1 << RoB_WIDTH;
    localparam int unsigned REG_NUM   = 32;
    localparam int unsigned REG_IDX_W = 5;
    localparam int unsigned XLEN      = 32;

    typedef enum logic [5:0] {
        INST_NONE  = 6'd0,
        INST_LUI   = 6'd1,
        INST_AUIPC = 6'd2,
        INST_JAL   = 6'd3,
        INST_JALR  = 6'd4,
        INST_BEQ   = 6'd5,
        INST_BNE   = 6'd6,
        INST_BLT   = 6'd7,
        INST_BGE   = 6'd8,
        INST_BLTU  = 6'd9,
        INST_BGEU  = 6'd10,
        INST_LB    = 6'd11,
        INST_LH    = 6'd12,
        INST_LW    = 6'd13,
        INST_LBU   = 6'd14,
        INST_LHU   = 6'd15,
        INST_SB    = 6'd16,
        INST_SH    = 6'd17,
        INST_SW    = 6'd18,
        INST_ADDI  = 6'd19,
        INST_SLTI  = 6'd20,
        INST_SLTIU = 6'd21,
        INST_XORI  = 6'd22,
        INST_ORI   = 6'd23,
        INST_ANDI  = 6'd24,
        INST_SLLI  = 6'd25,
        INST_SRLI  = 6'd26,
        INST_SRAI  = 6'd27,
        INST_ADD   = 6'd28,
        INST_SUB   = 6'd29,
        INST_SLL   = 6'd30,
        INST_SLT   = 6'd31,
        INST_SLTU  = 6'd32,
        INST_XORR  = 6'd33,
        INST_SRL   = 6'd34,
        INST_SRA   = 6'd35,
        INST_ORR   = 6'd36,
        INST_ANDR  = 6'd37
    } inst_type_t;

endpackage

// File: rtl/reg_file_read_port.sv
// One source-operand read port: x0 forcing and same-cycle commit bypass
// applied on top of the stored register entry.
module reg_file_read_port
    import reg_file_pkg::*;
#(
    parameter int unsigned TAG_W = RoB_WIDTH
) (
    input  logic [REG_IDX_W-1:0] rs_i,
    input  logic [XLEN-1:0]      st_val_i,
    input  logic                 st_busy_i,
    input  logic [TAG_W-1:0]     st_tag_i,
    input  logic                 commit_en_i,
    input  logic [REG_IDX_W-1:0] commit_rd_i,
    input  logic [TAG_W-1:0]     commit_tag_i,
    input  logic [XLEN-1:0]      commit_val_i,
    output logic [XLEN-1:0]      val_c,
    output logic                 busy_c,
    output logic [TAG_W-1:0]     tag_c
);

    logic is_x0;
    logic bypass;

    assign is_x0  = (rs_i == '0);
    assign bypass = commit_en_i && !is_x0 && (commit_rd_i == rs_i)
                    && st_busy_i && (st_tag_i == commit_tag_i);

    always_comb begin
        val_c  = st_val_i;
        busy_c = st_busy_i;
        tag_c  = st_busy_i ? st_tag_i : '0;
        if (is_x0) begin
            val_c  = '0;
            busy_c = 1'b0;
            tag_c  = '0;
        end else if (bypass) begin
            // Retiring producer matches: operand is ready this very cycle
            val_c  = commit_val_i;
            busy_c = 1'b0;
            tag_c  = '0;
        end
    end

endmodule

// File: rtl/reg_file.sv
// Committed architectural register file with per-register rename status
// (busy flag + youngest in-flight RoB tag), two read ports with commit bypass.
module reg_file #(
    parameter int unsigned RoB_WIDTH = reg_file_pkg::RoB_WIDTH,
    parameter int unsigned REG_NUM   = reg_file_pkg::REG_NUM
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 rdy_in,
    input  logic                 flush_in,
    input  logic [4:0]           rs1_in,
    input  logic [4:0]           rs2_in,
    output logic [31:0]          rs1_val_out,
    output logic [31:0]          rs2_val_out,
    output logic                 rs1_busy_out,
    output logic                 rs2_busy_out,
    output logic [RoB_WIDTH-1:0] rs1_tag_out,
    output logic [RoB_WIDTH-1:0] rs2_tag_out,
    input  logic                 rename_en_in,
    input  logic [4:0]           rename_rd_in,
    input  logic [RoB_WIDTH-1:0] rename_tag_in,
    input  logic                 commit_en_in,
    input  logic [4:0]           commit_rd_in,
    input  logic [RoB_WIDTH-1:0] commit_tag_in,
    input  logic [31:0]          commit_val_in
);

    logic [31:0]          val_q  [REG_NUM];
    logic [31:0]          val_d  [REG_NUM];
    logic [REG_NUM-1:0]   busy_q;
    logic [REG_NUM-1:0]   busy_d;
    logic [RoB_WIDTH-1:0] tag_q  [REG_NUM];
    logic [RoB_WIDTH-1:0] tag_d  [REG_NUM];

    logic commit_wr;
    logic rename_wr;
    logic flush_wr;

    assign commit_wr = rdy_in && commit_en_in && (commit_rd_in != '0);
    assign rename_wr = rdy_in && rename_en_in && (rename_rd_in != '0) && !flush_in;
    assign flush_wr  = rdy_in && flush_in;

    // Ordering commit -> flush -> rename gives rename priority on the same rd
    always_comb begin
        val_d  = val_q;
        busy_d = busy_q;
        tag_d  = tag_q;
        if (commit_wr) begin
            val_d[commit_rd_in] = commit_val_in;
            if (tag_q[commit_rd_in] == commit_tag_in) begin
                busy_d[commit_rd_in] = 1'b0;
                tag_d[commit_rd_in]  = '0;
            end
        end
        if (flush_wr) begin
            busy_d = '0;
            for (int i = 0; i < int'(REG_NUM); i++) begin
                tag_d[i] = '0;
            end
        end
        if (rename_wr) begin
            busy_d[rename_rd_in] = 1'b1;
            tag_d[rename_rd_in]  = rename_tag_in;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            busy_q <= '0;
            for (int i = 0; i < int'(REG_NUM); i++) begin
                val_q[i] <= '0;
                tag_q[i] <= '0;
            end
        end else begin
            val_q  <= val_d;
            busy_q <= busy_d;
            tag_q  <= tag_d;
        end
    end

    reg_file_read_port #(.TAG_W(RoB_WIDTH)) u_rd_port1 (
        .rs_i         (rs1_in),
        .st_val_i     (val_q[rs1_in]),
        .st_busy_i    (busy_q[rs1_in]),
        .st_tag_i     (tag_q[rs1_in]),
        .commit_en_i  (rdy_in && commit_en_in),
        .commit_rd_i  (commit_rd_in),
        .commit_tag_i (commit_tag_in),
        .commit_val_i (commit_val_in),
        .val_c        (rs1_val_out),
        .busy_c       (rs1_busy_out),
        .tag_c        (rs1_tag_out)
    );

    reg_file_read_port #(.TAG_W(RoB_WIDTH)) u_rd_port2 (
        .rs_i         (rs2_in),
        .st_val_i     (val_q[rs2_in]),
        .st_busy_i    (busy_q[rs2_in]),
        .st_tag_i     (tag_q[rs2_in]),
        .commit_en_i  (rdy_in && commit_en_in),
        .commit_rd_i  (commit_rd_in),
        .commit_tag_i (commit_tag_in),
        .commit_val_i (commit_val_in),
        .val_c        (rs2_val_out),
        .busy_c       (rs2_busy_out),
        .tag_c        (rs2_tag_out)
    );

endmodule

// File: tb/tb_reg_file.sv
// Self-checking bench for reg_file: directed scenarios plus randomized traffic
// compared against an array-based model of the register/rename rules.
module tb_reg_file;

    logic        clk_in;
    logic        rst_in;
    logic        rdy_in;
    logic        flush_in;
    logic [4:0]  rs1_in, rs2_in;
    logic [31:0] rs1_val_out, rs2_val_out;
    logic        rs1_busy_out, rs2_busy_out;
    logic [2:0]  rs1_tag_out, rs2_tag_out;
    logic        rename_en_in;
    logic [4:0]  rename_rd_in;
    logic [2:0]  rename_tag_in;
    logic        commit_en_in;
    logic [4:0]  commit_rd_in;
    logic [2:0]  commit_tag_in;
    logic [31:0] commit_val_in;

    int checks = 0;
    int errors = 0;

    logic [31:0] m_val  [32];
    bit          m_busy [32];
    logic [2:0]  m_tag  [32];

    reg_file dut (
        .clk_in        (clk_in),
        .rst_in        (rst_in),
        .rdy_in        (rdy_in),
        .flush_in      (flush_in),
        .rs1_in        (rs1_in),
        .rs2_in        (rs2_in),
        .rs1_val_out   (rs1_val_out),
        .rs2_val_out   (rs2_val_out),
        .rs1_busy_out  (rs1_busy_out),
        .rs2_busy_out  (rs2_busy_out),
        .rs1_tag_out   (rs1_tag_out),
        .rs2_tag_out   (rs2_tag_out),
        .rename_en_in  (rename_en_in),
        .rename_rd_in  (rename_rd_in),
        .rename_tag_in (rename_tag_in),
        .commit_en_in  (commit_en_in),
        .commit_rd_in  (commit_rd_in),
        .commit_tag_in (commit_tag_in),
        .commit_val_in (commit_val_in)
    );

    initial begin
        clk_in = 1'b0;
        forever #5 clk_in = ~clk_in;
    end

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s obs=0x%08h exp=0x%08h t=%0t", name, obs, exp, $time);
        end
    endtask

    // Expected read: a retiring producer that matches the current rename makes the value ready now
    task automatic exp_read(input logic [4:0] rs, output logic [31:0] v,
                            output logic b, output logic [2:0] t);
        if (rs == 5'd0) begin
            v = 32'd0; b = 1'b0; t = 3'd0;
        end else if (rdy_in && commit_en_in && commit_rd_in == rs && m_busy[rs]
                     && m_tag[rs] == commit_tag_in) begin
            v = commit_val_in; b = 1'b0; t = 3'd0;
        end else begin
            v = m_val[rs]; b = m_busy[rs]; t = m_busy[rs] ? m_tag[rs] : 3'd0;
        end
    endtask

    task automatic check_reads();
        logic [31:0] v;
        logic        b;
        logic [2:0]  t;
        exp_read(rs1_in, v, b, t);
        chk("rs1_val", rs1_val_out, v);
        chk("rs1_busy", 32'(rs1_busy_out), 32'(b));
        chk("rs1_tag", 32'(rs1_tag_out), 32'(t));
        exp_read(rs2_in, v, b, t);
        chk("rs2_val", rs2_val_out, v);
        chk("rs2_busy", 32'(rs2_busy_out), 32'(b));
        chk("rs2_tag", 32'(rs2_tag_out), 32'(t));
    endtask

    task automatic model_tick();
        if (rst_in) begin
            for (int i = 0; i < 32; i++) begin
                m_val[i] = 32'd0; m_busy[i] = 1'b0; m_tag[i] = 3'd0;
            end
        end else if (rdy_in) begin
            if (commit_en_in && commit_rd_in != 5'd0) begin
                m_val[commit_rd_in] = commit_val_in;
                if (m_busy[commit_rd_in] && m_tag[commit_rd_in] == commit_tag_in)
                    m_busy[commit_rd_in] = 1'b0;
            end
            if (flush_in) begin
                for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
            end else if (rename_en_in && rename_rd_in != 5'd0) begin
                m_busy[rename_rd_in] = 1'b1;
                m_tag[rename_rd_in]  = rename_tag_in;
            end
        end
    endtask

    task automatic settle();
        #4;
        check_reads();
    endtask

    task automatic tick();
        @(posedge clk_in);
        model_tick();
        #1;
    endtask

    task automatic idle();
        rst_in = 1'b0; rdy_in = 1'b1; flush_in = 1'b0;
        rename_en_in = 1'b0; rename_rd_in = 5'd0; rename_tag_in = 3'd0;
        commit_en_in = 1'b0; commit_rd_in = 5'd0; commit_tag_in = 3'd0;
        commit_val_in = 32'd0;
    endtask

    task automatic ren(input logic [4:0] rd, input logic [2:0] tg);
        rename_en_in = 1'b1; rename_rd_in = rd; rename_tag_in = tg;
    endtask

    task automatic cmt(input logic [4:0] rd, input logic [2:0] tg, input logic [31:0] v);
        commit_en_in = 1'b1; commit_rd_in = rd; commit_tag_in = tg; commit_val_in = v;
    endtask

    initial begin
        idle();
        rs1_in = 5'd5; rs2_in = 5'd31;
        rst_in = 1'b1;
        tick();
        rst_in = 1'b0;

        // Reset contents
        settle();
        chk("rst_x5_val", rs1_val_out, 32'd0);
        chk("rst_x31_busy", 32'(rs2_busy_out), 32'd0);
        tick();

        // Rename then matching commit: bypass, then storage
        ren(5'd3, 3'd2); settle(); tick();
        idle(); cmt(5'd3, 3'd2, 32'hDEADBEEF); rs1_in = 5'd3;
        settle();
        chk("bypass_val", rs1_val_out, 32'hDEADBEEF);
        chk("bypass_busy", 32'(rs1_busy_out), 32'd0);
        tick();
        idle(); settle();
        chk("commit_val", rs1_val_out, 32'hDEADBEEF);
        chk("commit_busy", 32'(rs1_busy_out), 32'd0);
        tick();

        // Stale commit after re-rename leaves busy with the younger tag
        ren(5'd4, 3'd1); settle(); tick();
        ren(5'd4, 3'd5); settle(); tick();
        idle(); cmt(5'd4, 3'd1, 32'd7); rs1_in = 5'd4; settle(); tick();
        idle(); settle();
        chk("stale_val", rs1_val_out, 32'd7);
        chk("stale_busy", 32'(rs1_busy_out), 32'd1);
        chk("stale_tag", 32'(rs1_tag_out), 32'd5);
        tick();

        // Same-cycle rename and commit on x6
        ren(5'd6, 3'd0); settle(); tick();
        idle(); ren(5'd6, 3'd3); cmt(5'd6, 3'd0, 32'd9); rs1_in = 5'd6;
        settle();
        chk("same_byp_val", rs1_val_out, 32'd9);
        chk("same_byp_busy", 32'(rs1_busy_out), 32'd0);
        tick();
        idle(); settle();
        chk("same_val", rs1_val_out, 32'd9);
        chk("same_busy", 32'(rs1_busy_out), 32'd1);
        chk("same_tag", 32'(rs1_tag_out), 32'd3);
        tick();

        // Flush with a commit and a dropped rename
        for (int i = 1; i <= 7; i++) begin
            idle(); ren(5'(i), 3'(i)); settle(); tick();
        end
        idle(); flush_in = 1'b1; cmt(5'd1, 3'd1, 32'h10); ren(5'd8, 3'd4);
        rs1_in = 5'd1; rs2_in = 5'd8; settle(); tick();
        idle(); settle();
        chk("flush_x1_val", rs1_val_out, 32'h10);
        chk("flush_x8_busy", 32'(rs2_busy_out), 32'd0);
        tick();
        for (int i = 1; i <= 7; i++) begin
            rs1_in = 5'(i); settle();
            chk("flush_busy", 32'(rs1_busy_out), 32'd0);
            tick();
        end

        // rdy_in low freezes state and disables bypass
        ren(5'd2, 3'd6); settle(); tick();
        idle(); rdy_in = 1'b0; ren(5'd2, 3'd1); cmt(5'd2, 3'd6, 32'h55); rs1_in = 5'd2;
        settle();
        chk("nordy_byp_busy", 32'(rs1_busy_out), 32'd1);
        tick();
        idle(); settle();
        chk("nordy_busy", 32'(rs1_busy_out), 32'd1);
        chk("nordy_tag", 32'(rs1_tag_out), 32'd6);
        chk("nordy_val", rs1_val_out, 32'd0);
        tick();

        // x0 writes ignored
        ren(5'd0, 3'd3); cmt(5'd0, 3'd3, 32'd5); rs1_in = 5'd0; settle(); tick();
        idle(); settle();
        chk("x0_val", rs1_val_out, 32'd0);
        chk("x0_busy", 32'(rs1_busy_out), 32'd0);
        tick();

        // Randomized traffic, commits biased toward live renames to exercise bypass
        for (int n = 0; n < 800; n++) begin
            idle();
            rst_in   = ($urandom_range(0, 199) == 0);
            rdy_in   = ($urandom_range(0, 9) != 0);
            flush_in = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 1) == 1) ren(5'($urandom), 3'($urandom));
            if ($urandom_range(0, 1) == 1) begin
                logic [4:0] rd;
                logic [2:0] tg;
                rd = 5'($urandom);
                tg = 3'($urandom);
                if ($urandom_range(0, 9) < 7) begin
                    int s;
                    s = int'($urandom_range(0, 31));
                    for (int k = 0; k < 32; k++) begin
                        if (m_busy[(s + k) % 32]) begin
                            rd = 5'((s + k) % 32);
                            tg = m_tag[rd];
                            break;
                        end
                    end
                end
                cmt(rd, tg, $urandom);
            end
            rs1_in = ($urandom_range(0, 2) == 0) ? commit_rd_in : 5'($urandom);
            rs2_in = ($urandom_range(0, 2) == 0) ? rename_rd_in : 5'($urandom);
            settle();
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
